msp430_mpsoc_ext_spram_bank: RTL and testbench

// - Shared external scratchpad for the MPSoC bb_ext_* bus. Replaces one private RAM per node.
// - NODES request ports drive BANKS interleaved single-port RAM banks, each DEPTH words deep.
// - Each bank has its own round-robin arbiter, so different nodes can reach different banks in the same cycle.
// - Adds byte-enable writes, configurable read latency and out-of-range error reporting.
// - Sits between msp430_mpsoc3d (bb_ext_* ports) and the synthesis wrappers.

---
 rtl/msp430_mpsoc_ext_spram_bank_if.sv | 27 ++
 rtl/msp430_mpsoc_ext_spram_bank.sv | 189 ++++++++++++++++++
 tb/tb_msp430_mpsoc_ext_spram_bank.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/msp430_mpsoc_ext_spram_bank_if.sv
// Request/response bundle between the MPSoC nodes and the shared external scratchpad.
interface msp430_mpsoc_ext_spram_bank_if #(
    parameter int unsigned NODES = 8,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    logic [NODES-1:0]      req_en;
    logic [NODES-1:0]      req_we;
    logic [NODES*AW-1:0]   req_addr;
    logic [NODES*DW-1:0]   req_din;
    logic [NODES*DW/8-1:0] req_be;
    logic [NODES-1:0]      req_gnt;
    logic [NODES-1:0]      rsp_valid;
    logic [NODES*DW-1:0]   rsp_dout;
    logic [NODES-1:0]      rsp_err;
    logic [NODES-1:0]      wr_err;

    modport master (
        output req_en, req_we, req_addr, req_din, req_be,
        input  req_gnt, rsp_valid, rsp_dout, rsp_err, wr_err
    );

    modport slave (
        input  req_en, req_we, req_addr, req_din, req_be,
        output req_gnt, rsp_valid, rsp_dout, rsp_err, wr_err
    );
endinterface

// File: rtl/msp430_mpsoc_ext_spram_bank.sv
// Shared scratchpad: NODES requesters onto BANKS word-interleaved single-port RAM banks,
// one round-robin arbiter per bank, byte-enable writes, READ_LAT of 1 or 2.
module msp430_mpsoc_ext_spram_bank #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned NODES    = 8,
    parameter int unsigned BANKS    = 4,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    msp430_mpsoc_ext_spram_bank_if.slave  bus
);
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned BSH  = (BW > 1) ? $clog2(BW) : 0;
    localparam int unsigned BKSH = (BANKS > 1) ? $clog2(BANKS) : 0;
    localparam int unsigned BKW  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned NW   = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int unsigned RW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    w_word     [NODES];
    logic [AW-1:0]    w_row_full [NODES];
    logic [BKW-1:0]   w_bank     [NODES];
    logic [RW-1:0]    w_row      [NODES];
    logic [NODES-1:0] w_oor;

    // Address decode; the full-width row is kept so out-of-range rows are never aliased
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            w_word[n]     = bus.req_addr[n*AW +: AW] >> BSH;
            w_row_full[n] = w_word[n] >> BKSH;
            w_bank[n]     = (BANKS > 1) ? BKW'(w_word[n]) : '0;
            w_row[n]      = RW'(w_row_full[n]);
            w_oor[n]      = (w_row_full[n] >= AW'(DEPTH));
        end
    end

    logic [NW-1:0]    r_ptr   [BANKS];
    logic [NW-1:0]    w_win   [BANKS];
    logic [NW-1:0]    w_idx;
    logic [BANKS-1:0] w_act;
    logic [NODES-1:0] w_gnt;
    logic [BANKS-1:0] w_b_we;
    logic [BANKS-1:0] w_b_ok;
    logic [RW-1:0]    w_b_row [BANKS];
    logic [DW-1:0]    w_b_din [BANKS];
    logic [BW-1:0]    w_b_be  [BANKS];

    // Per-bank round-robin search starting after the last winner; nothing wins under reset
    always_comb begin
        w_act = '0;
        w_gnt = '0;
        w_idx = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_win[b] = r_ptr[b];
            for (int unsigned k = 1; k <= NODES; k++) begin
                w_idx = NW'((32'(r_ptr[b]) + k) % NODES);
                if (!w_act[b] && bus.req_en[w_idx] && (w_bank[w_idx] == BKW'(b))) begin
                    w_act[b] = 1'b1;
                    w_win[b] = w_idx;
                end
            end
            if (rst) begin
                w_act[b] = 1'b0;
            end
            if (w_act[b]) begin
                w_gnt[w_win[b]] = 1'b1;
            end
            w_b_we[b]  = bus.req_we[w_win[b]];
            w_b_ok[b]  = w_act[b] & ~w_oor[w_win[b]];
            w_b_row[b] = w_row[w_win[b]];
            w_b_din[b] = bus.req_din[32'(w_win[b])*DW +: DW];
            w_b_be[b]  = bus.req_be[32'(w_win[b])*BW +: BW];
        end
    end

    logic [DW-1:0] r_mem [BANKS][DEPTH];
    logic [DW-1:0] r_rd  [BANKS];

    // RAM banks: one access per bank per cycle, contents not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (w_b_ok[b]) begin
                if (w_b_we[b]) begin
                    for (int i = 0; i < BW; i++) begin
                        if (w_b_be[b][i]) begin
                            r_mem[b][w_b_row[b]][8*i +: 8] <= w_b_din[b][8*i +: 8];
                        end
                    end
                end else begin
                    r_rd[b] <= r_mem[b][w_b_row[b]];
                end
            end
        end
    end

    logic [NODES-1:0] r_s1_v;
    logic [NODES-1:0] r_s1_err;
    logic [NODES-1:0] r_wr_err;
    logic [BKW-1:0]   r_s1_bank [NODES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= '0;
            r_s1_err <= '0;
            r_wr_err <= '0;
            for (int b = 0; b < BANKS; b++) begin
                r_ptr[b] <= NW'(NODES - 1);
            end
            for (int n = 0; n < NODES; n++) begin
                r_s1_bank[n] <= '0;
            end
        end else begin
            r_s1_v   <= w_gnt & ~bus.req_we;
            r_s1_err <= w_oor;
            r_wr_err <= w_gnt & bus.req_we & w_oor;
            for (int b = 0; b < BANKS; b++) begin
                if (w_act[b]) begin
                    r_ptr[b] <= w_win[b];
                end
            end
            for (int n = 0; n < NODES; n++) begin
                r_s1_bank[n] <= w_bank[n];
            end
        end
    end

    logic [DW-1:0]       w_d1 [NODES];
    logic [NODES-1:0]    w_v;
    logic [NODES-1:0]    w_e;
    logic [NODES*DW-1:0] w_dout;

    // A node's read result is whatever its bank latched; out-of-range reads return zero
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            w_d1[n] = (r_s1_v[n] && !r_s1_err[n]) ? r_rd[r_s1_bank[n]] : '0;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [NODES-1:0] r_s2_v;
            logic [NODES-1:0] r_s2_err;
            logic [DW-1:0]    r_s2_d [NODES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_v   <= '0;
                    r_s2_err <= '0;
                    for (int n = 0; n < NODES; n++) begin
                        r_s2_d[n] <= '0;
                    end
                end else begin
                    r_s2_v   <= r_s1_v;
                    r_s2_err <= r_s1_v & r_s1_err;
                    for (int n = 0; n < NODES; n++) begin
                        r_s2_d[n] <= w_d1[n];
                    end
                end
            end

            always_comb begin
                w_dout = '0;
                for (int n = 0; n < NODES; n++) begin
                    w_dout[n*DW +: DW] = r_s2_d[n];
                end
            end
            assign w_v = r_s2_v;
            assign w_e = r_s2_err;
        end else begin : g_lat1
            always_comb begin
                w_dout = '0;
                for (int n = 0; n < NODES; n++) begin
                    w_dout[n*DW +: DW] = w_d1[n];
                end
            end
            assign w_v = r_s1_v;
            assign w_e = r_s1_v & r_s1_err;
        end
    endgenerate

    // Responses are suppressed while reset is held
    assign bus.req_gnt   = w_gnt;
    assign bus.rsp_valid = w_v & {NODES{~rst}};
    assign bus.rsp_err   = w_e & {NODES{~rst}};
    assign bus.wr_err    = r_wr_err & {NODES{~rst}};
    assign bus.rsp_dout  = rst ? '0 : w_dout;
endmodule

// File: tb/tb_msp430_mpsoc_ext_spram_bank.sv
// Directed bench for the shared scratchpad: one READ_LAT=1 instance and one READ_LAT=2 instance.
module tb_msp430_mpsoc_ext_spram_bank;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned NODES = 8;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0] exp_g [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02, 8'h04, 8'h08};

    always #5 clk = ~clk;

    msp430_mpsoc_ext_spram_bank_if #(.NODES(NODES), .AW(AW), .DW(DW)) bus  ();
    msp430_mpsoc_ext_spram_bank_if #(.NODES(NODES), .AW(AW), .DW(DW)) bus2 ();

    msp430_mpsoc_ext_spram_bank #(
        .AW(AW), .DW(DW), .NODES(NODES), .BANKS(4), .DEPTH(256), .READ_LAT(1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    msp430_mpsoc_ext_spram_bank #(
        .AW(AW), .DW(DW), .NODES(NODES), .BANKS(4), .DEPTH(256), .READ_LAT(2)
    ) u_dut2 (
        .clk(clk),
        .rst(rst2),
        .bus(bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit two, input int n, input logic we, input logic [31:0] addr,
                       input logic [31:0] din, input logic [3:0] be);
        if (two) begin
            bus2.req_en[n] = 1'b1;
            bus2.req_we[n] = we;
            bus2.req_addr[n*AW +: AW] = addr;
            bus2.req_din[n*DW +: DW] = din;
            bus2.req_be[n*4 +: 4] = be;
        end else begin
            bus.req_en[n] = 1'b1;
            bus.req_we[n] = we;
            bus.req_addr[n*AW +: AW] = addr;
            bus.req_din[n*DW +: DW] = din;
            bus.req_be[n*4 +: 4] = be;
        end
    endtask

    task automatic idle();
        bus.req_en  = '0;
        bus2.req_en = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        bus.req_en = '0;   bus.req_we = '0;   bus.req_addr = '0;   bus.req_din = '0;   bus.req_be = '0;
        bus2.req_en = '0;  bus2.req_we = '0;  bus2.req_addr = '0;  bus2.req_din = '0;  bus2.req_be = '0;
        rst  = 1'b1;
        rst2 = 1'b1;

        // Reset: a pending request is not granted, outputs at zero
        req(0, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        nxt();
        smp();
        chk("rst_gnt",   32'(bus.req_gnt),   32'h0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_err",   32'(bus.rsp_err),   32'h0);
        chk("rst_wrerr", 32'(bus.wr_err),    32'h0);
        chk("rst_dout",  bus.rsp_dout[0 +: 32], 32'h0);
        nxt();
        rst  = 1'b0;
        rst2 = 1'b0;
        idle();

        // Single write then read on node 0
        req(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        smp(); chk("wr_gnt", 32'(bus.req_gnt), 32'h01); nxt();
        req(0, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        smp(); chk("rd_gnt", 32'(bus.req_gnt), 32'h01); chk("wr_no_rsp", 32'(bus.rsp_valid), 32'h0); nxt();
        idle();
        smp();
        chk("rd_valid", 32'(bus.rsp_valid), 32'h01);
        chk("rd_dout",  bus.rsp_dout[0 +: 32], 32'hDEADBEEF);
        chk("rd_err",   32'(bus.rsp_err), 32'h0);
        nxt();
        smp(); chk("rd_pulse", 32'(bus.rsp_valid), 32'h0); nxt();

        // Byte enables
        req(0, 0, 1'b1, 32'h20, 32'h11223344, 4'hF); smp(); nxt();
        req(0, 0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5); smp(); nxt();
        req(0, 0, 1'b0, 32'h20, 32'h0, 4'h0);        smp(); nxt();
        idle();
        smp(); chk("be_dout", bus.rsp_dout[0 +: 32], 32'h11BB33DD); nxt();

        // Bank conflict after reset: nodes 0-3 read bank 0 every cycle
        rst = 1'b1; smp(); nxt(); rst = 1'b0;
        for (int k = 0; k < 4; k++) req(0, k, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("conf_gnt", 32'(bus.req_gnt), 32'(exp_g[i]));
            if (i > 0) chk("conf_valid", 32'(bus.rsp_valid), 32'(exp_g[i-1]));
            nxt();
        end
        idle();
        smp();
        chk("conf_last_valid", 32'(bus.rsp_valid), 32'h08);
        chk("conf_last_dout",  bus.rsp_dout[3*32 +: 32], 32'hDEADBEEF);
        nxt();

        // Parallel banks: nodes 0-3 hit banks 0-3
        for (int k = 0; k < 4; k++) req(0, k, 1'b1, 32'h10 + 32'(4*k), 32'hA0000000 + 32'(k), 4'hF);
        smp(); chk("par_wr_gnt", 32'(bus.req_gnt), 32'h0F); nxt();
        for (int k = 0; k < 4; k++) req(0, k, 1'b0, 32'h10 + 32'(4*k), 32'h0, 4'h0);
        smp(); chk("par_rd_gnt", 32'(bus.req_gnt), 32'h0F); nxt();
        idle();
        smp();
        chk("par_valid", 32'(bus.rsp_valid), 32'h0F);
        chk("par_dout0", bus.rsp_dout[0*32 +: 32], 32'hA0000000);
        chk("par_dout1", bus.rsp_dout[1*32 +: 32], 32'hA0000001);
        chk("par_dout2", bus.rsp_dout[2*32 +: 32], 32'hA0000002);
        chk("par_dout3", bus.rsp_dout[3*32 +: 32], 32'hA0000003);
        nxt();

        // Out-of-range read at word 1024
        req(0, 2, 1'b0, 32'h1000, 32'h0, 4'h0);
        smp(); chk("oor_rd_gnt", 32'(bus.req_gnt), 32'h04); nxt();
        idle();
        smp();
        chk("oor_valid", 32'(bus.rsp_valid), 32'h04);
        chk("oor_err",   32'(bus.rsp_err),   32'h04);
        chk("oor_dout",  bus.rsp_dout[2*32 +: 32], 32'h0);
        nxt();

        // Out-of-range write must not alias onto row 0
        req(0, 1, 1'b1, 32'h0, 32'h12345678, 4'hF); smp(); nxt();
        req(0, 1, 1'b1, 32'h1000, 32'h55555555, 4'hF);
        smp(); chk("oor_wr_gnt", 32'(bus.req_gnt), 32'h02); nxt();
        req(0, 1, 1'b0, 32'h0, 32'h0, 4'h0);
        smp(); chk("oor_wrerr", 32'(bus.wr_err), 32'h02); nxt();
        idle();
        smp();
        chk("oor_wrerr_pulse", 32'(bus.wr_err), 32'h0);
        chk("oor_wr_ram",      bus.rsp_dout[1*32 +: 32], 32'h12345678);
        chk("oor_wr_rderr",    32'(bus.rsp_err), 32'h0);
        nxt();

        // READ_LAT=2 latency
        req(1, 0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF); smp(); nxt();
        req(1, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        smp(); chk("l2_gnt", 32'(bus2.req_gnt), 32'h01); nxt();
        idle();
        smp(); chk("l2_early", 32'(bus2.rsp_valid), 32'h0); nxt();
        smp(); chk("l2_valid", 32'(bus2.rsp_valid), 32'h01); chk("l2_dout", bus2.rsp_dout[0 +: 32], 32'hCAFEF00D); nxt();
        smp(); chk("l2_pulse", 32'(bus2.rsp_valid), 32'h0); nxt();

        // Reset one cycle after a read grant: response dropped, pointer restored
        req(1, 1, 1'b0, 32'h10, 32'h0, 4'h0);
        smp(); chk("mr_gnt", 32'(bus2.req_gnt), 32'h02); nxt();
        idle();
        rst2 = 1'b1;
        req(1, 0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
        smp(); chk("mr_rst_gnt", 32'(bus2.req_gnt), 32'h0); chk("mr_rst_valid", 32'(bus2.rsp_valid), 32'h0); nxt();
        rst2 = 1'b0;
        idle();
        smp(); chk("mr_valid1", 32'(bus2.rsp_valid), 32'h0); nxt();
        smp(); chk("mr_valid2", 32'(bus2.rsp_valid), 32'h0); nxt();
        req(1, 0, 1'b0, 32'h10, 32'h0, 4'h0);
        req(1, 2, 1'b0, 32'h10, 32'h0, 4'h0);
        smp(); chk("mr_restart_gnt", 32'(bus2.req_gnt), 32'h01); nxt();
        idle();
        smp(); nxt();
        smp();
        chk("mr_rd_valid", 32'(bus2.rsp_valid), 32'h01);
        chk("mr_rd_dout",  bus2.rsp_dout[0 +: 32], 32'hCAFEF00D);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
